// File: rtl/filter_pad_streamer.sv
// Streams an unpadded RGB888 frame out as a zero-padded raster with trailing
// flush rows, ready for a row-buffer convolution filter downstream.
module filter_pad_streamer #(
    parameter int width       = 320,
    parameter int height      = 240,
    parameter int kernel_size = 3,
    parameter int flush_rows  = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        iStart,
    input  logic        iValid,
    input  logic [23:0] iData,
    output logic        oReady,
    output logic        oValid,
    output logic [23:0] oData,
    output logic        oBusy,
    output logic        oFrameDone
);
    // state   | meaning
    // S_IDLE  | waiting for iStart, upstream not ready
    // S_PAD   | whole zero row (top, bottom or flush)
    // S_LEFT  | leading zero beats of a data row
    // S_DATA  | forwarding upstream pixels, one per transfer
    // S_RIGHT | trailing zero beats of a data row
    // S_DONE  | last beat on the output, frame-done pulse follows
    typedef enum logic [2:0] {S_IDLE, S_PAD, S_LEFT, S_DATA, S_RIGHT, S_DONE} state_t;

    localparam int BW = (kernel_size - 1) / 2;
    localparam int L  = width + 2 * BW;
    localparam int R  = height + 2 * BW + flush_rows;

    localparam logic [12:0] COL_LAST    = 13'(L - 1);
    localparam logic [12:0] LEFT_LAST   = 13'(BW - 1);
    localparam logic [12:0] DATA_LAST   = 13'(BW + width - 1);
    localparam logic [12:0] ROW_LAST    = 13'(R - 1);
    localparam logic [12:0] ROW_DATA_LO = 13'(BW);
    localparam logic [12:0] ROW_DATA_HI = 13'(BW + height);

    state_t      state;
    state_t      row_end_state;
    logic [12:0] col_cnt;
    logic [12:0] row_cnt;

    // With no border the row starts straight in DATA.
    function automatic state_t row_entry(input logic [12:0] r);
        if (r >= ROW_DATA_LO && r < ROW_DATA_HI)
            return (BW > 0) ? S_LEFT : S_DATA;
        return S_PAD;
    endfunction

    always_comb begin
        row_end_state = S_DONE;
        if (row_cnt != ROW_LAST)
            row_end_state = row_entry(row_cnt + 13'd1);
    end

    assign oReady = reset_n && (state == S_DATA);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            col_cnt    <= '0;
            row_cnt    <= '0;
            oValid     <= 1'b0;
            oData      <= '0;
            oBusy      <= 1'b0;
            oFrameDone <= 1'b0;
        end else begin
            oValid     <= 1'b0;
            oData      <= '0;
            oFrameDone <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (iStart) begin
                        state   <= row_entry(13'd0);
                        oBusy   <= 1'b1;
                        col_cnt <= '0;
                        row_cnt <= '0;
                    end
                end
                S_PAD, S_RIGHT: begin
                    oValid <= 1'b1;
                    if (col_cnt == COL_LAST) begin
                        col_cnt <= '0;
                        row_cnt <= row_cnt + 13'd1;
                        state   <= row_end_state;
                    end else begin
                        col_cnt <= col_cnt + 13'd1;
                    end
                end
                S_LEFT: begin
                    oValid  <= 1'b1;
                    col_cnt <= col_cnt + 13'd1;
                    if (col_cnt == LEFT_LAST)
                        state <= S_DATA;
                end
                S_DATA: begin
                    if (iValid) begin
                        oValid <= 1'b1;
                        oData  <= iData;
                        if (col_cnt == DATA_LAST && BW == 0) begin
                            col_cnt <= '0;
                            row_cnt <= row_cnt + 13'd1;
                            state   <= row_end_state;
                        end else begin
                            col_cnt <= col_cnt + 13'd1;
                            if (col_cnt == DATA_LAST)
                                state <= S_RIGHT;
                        end
                    end
                end
                S_DONE: begin
                    oFrameDone <= 1'b1;
                    oBusy      <= 1'b0;
                    col_cnt    <= '0;
                    row_cnt    <= '0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_filter_pad_streamer.sv
// Bench for filter_pad_streamer: two configurations (3x3 and 7x7 borders)
// driven with random pixels and compared against a raster-layout model.
module tb_filter_pad_streamer;
    localparam int PW[2] = '{4, 8};
    localparam int PH[2] = '{2, 3};
    localparam int PB[2] = '{1, 3};
    localparam int PF[2] = '{1, 1};

    logic        clk;
    logic        rst_n;
    logic [1:0]  start;
    logic [1:0]  ivalid;
    logic [23:0] idata [2];
    logic [1:0]  rdy, ov, busy, fdone;
    logic [23:0] odata [2];

    int checks = 0;
    int failures = 0;

    logic [23:0] src   [2][256];
    logic [23:0] obeat [2][512];
    int          ocyc  [2][512];
    int ocount[2]   = '{0, 0};
    int fd_count[2] = '{0, 0};
    int fd_cyc[2]   = '{0, 0};
    int busy_err[2] = '{0, 0};
    int idle_rdy_err = 0;
    int idx[2]  = '{0, 0};
    int mode[2] = '{0, 0};
    int cyc = 0;
    logic [1:0] tog = '0;

    filter_pad_streamer #(.width(4), .height(2), .kernel_size(3), .flush_rows(1)) u_dut3 (
        .clk(clk), .reset_n(rst_n), .iStart(start[0]), .iValid(ivalid[0]), .iData(idata[0]),
        .oReady(rdy[0]), .oValid(ov[0]), .oData(odata[0]), .oBusy(busy[0]), .oFrameDone(fdone[0]));

    filter_pad_streamer #(.width(8), .height(3), .kernel_size(7), .flush_rows(1)) u_dut7 (
        .clk(clk), .reset_n(rst_n), .iStart(start[1]), .iValid(ivalid[1]), .iData(idata[1]),
        .oReady(rdy[1]), .oValid(ov[1]), .oData(odata[1]), .oBusy(busy[1]), .oFrameDone(fdone[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int d = 0; d < 2; d++)
            if (ivalid[d] && rdy[d] && rst_n)
                idx[d] <= idx[d] + 1;
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            tog[d] = ~tog[d];
            case (mode[d])
                0:       ivalid[d] = 1'b1;
                1:       ivalid[d] = tog[d];
                default: ivalid[d] = 1'($urandom_range(0, 1));
            endcase
            idata[d] = (idx[d] < 256) ? src[d][idx[d]] : 24'h0;
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (ov[d] === 1'b1 && ocount[d] < 512) begin
                obeat[d][ocount[d]] = odata[d];
                ocyc[d][ocount[d]]  = cyc;
                ocount[d]++;
                if (busy[d] !== 1'b1) busy_err[d]++;
            end
            if (fdone[d] === 1'b1) begin
                fd_count[d]++;
                fd_cyc[d] = cyc;
            end
            if (rst_n && busy[d] === 1'b0 && rdy[d] === 1'b1) idle_rdy_err++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Expected raster rebuilt from the layout rules: zero everywhere except the
    // data window, which consumes source pixels in order.
    task automatic check_frame(input int d, input int ib, input int ob, input int fb, input bit gaps_ok);
        int l, rr, nexp, n, p, gerr, r, c;
        bit dpos;
        logic [23:0] exp;
        l    = PW[d] + 2 * PB[d];
        rr   = PH[d] + 2 * PB[d] + PF[d];
        nexp = l * rr;
        n    = ocount[d] - ob;
        chk($sformatf("beat_count_d%0d", d), n, nexp);
        p = ib;
        gerr = 0;
        for (int k = 0; k < nexp; k++) begin
            r = k / l;
            c = k % l;
            dpos = (r >= PB[d]) && (r < PB[d] + PH[d]) && (c >= PB[d]) && (c < PB[d] + PW[d]);
            exp = dpos ? src[d][p] : 24'h0;
            if (dpos) p++;
            if (k < n) begin
                chk($sformatf("beat_d%0d_r%0d_c%0d", d, r, c), obeat[d][ob + k], exp);
                if (k > 0 && (ocyc[d][ob + k] - ocyc[d][ob + k - 1]) != 1 && !(gaps_ok && dpos))
                    gerr++;
            end
        end
        chk($sformatf("xfer_count_d%0d", d), idx[d] - ib, PW[d] * PH[d]);
        chk($sformatf("done_pulses_d%0d", d), fd_count[d] - fb, 1);
        if (n > 0) chk($sformatf("done_timing_d%0d", d), fd_cyc[d], ocyc[d][ob + n - 1] + 1);
        chk($sformatf("gap_rule_d%0d", d), gerr, 0);
        chk($sformatf("busy_during_beats_d%0d", d), busy_err[d], 0);
        chk("ready_while_idle", idle_rdy_err, 0);
    endtask

    task automatic run_frame(input int d);
        int ib, ob, fb, t;
        ib = idx[d];
        ob = ocount[d];
        fb = fd_count[d];
        start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
        chk($sformatf("busy_after_start_d%0d", d), busy[d], 1);
        t = 0;
        while (fd_count[d] == fb && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("frame_done_seen_d%0d", d), fd_count[d] != fb, 1);
        repeat (5) @(negedge clk);
        chk($sformatf("busy_after_done_d%0d", d), busy[d], 0);
        check_frame(d, ib, ob, fb, mode[d] != 0);
    endtask

    initial begin
        int ib, ob, fb, nb, t, lr;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 256; i++)
                src[d][i] = 24'($urandom);
        rst_n = 1'b0;
        start = '0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_ovalid_d%0d", d), ov[d], 0);
            chk($sformatf("rst_odata_d%0d", d), odata[d], 0);
            chk($sformatf("rst_busy_d%0d", d), busy[d], 0);
            chk($sformatf("rst_ready_d%0d", d), rdy[d], 0);
            chk($sformatf("rst_done_d%0d", d), fdone[d], 0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ready", rdy[0], 0);

        // contiguous frame, iValid held high
        mode[0] = 0;
        run_frame(0);

        // alternating iValid
        mode[0] = 1;
        run_frame(0);

        // 7x7 border, random iValid
        mode[1] = 2;
        run_frame(1);

        // reset while forwarding pixels, then a clean frame
        mode[0] = 2;
        fb = fd_count[0];
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        t = 0;
        while (rdy[0] !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("t4_reached_data", rdy[0], 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t4_ovalid", ov[0], 0);
        chk("t4_busy", busy[0], 0);
        chk("t4_ready", rdy[0], 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t4_ready_after", rdy[0], 0);
        chk("t4_ovalid_after", ov[0], 0);
        repeat (20) @(negedge clk);
        chk("t4_no_done", fd_count[0] - fb, 0);
        run_frame(0);

        // iStart mid-frame and in the DONE cycle must be ignored
        lr = (PW[0] + 2 * PB[0]) * (PH[0] + 2 * PB[0] + PF[0]);
        ib = idx[0];
        ob = ocount[0];
        fb = fd_count[0];
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        nb = 0;
        t = 0;
        while (nb < lr && t < 3000) begin
            @(negedge clk);
            if (ov[0] === 1'b1) nb++;
            start[0] = (t == 10) || (nb == lr);
            t++;
        end
        chk("t5_beats_seen", nb, lr);
        @(negedge clk);
        start[0] = 1'b0;
        repeat (20) @(negedge clk);
        chk("t5_idle_busy", busy[0], 0);
        check_frame(0, ib, ob, fb, 1'b1);
        run_frame(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
